y_output_checker: RTL and testbench

//  Downstream checker for the fuzz-generated `top` DUT. Compares the synthesized

---
 rtl/y_output_checker.sv | 88 ++++++++
 tb/tb_y_output_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/y_output_checker.sv
// y_output_checker: compares netlist vs golden y per valid cycle, counts mismatches, records first failure, builds a MISR signature
module y_output_checker #(
  parameter int          WIDTH   = 360,
  parameter int          WARMUP  = 2,
  parameter int          NCYCLES = 20,
  parameter logic [31:0] POLY    = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [15:0]      fail_count,
  output logic [15:0]      first_fail_cycle,
  output logic [8:0]       first_diff_bit,
  output logic [31:0]      signature
);
  localparam int NCH = (WIDTH + 31) / 32;
  localparam int PW  = NCH * 32;
  typedef enum logic [1:0] {IDLE, WARM, CMP, DONE} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        differ;
  logic [8:0]  low_bit;
  logic [PW-1:0] pad;
  logic [31:0] fold;
  // Case-equality per bit so X/Z count as differences; chunk-XOR fold of y_dut for the MISR
  always_comb begin
    differ  = 1'b0;
    low_bit = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (y_ref[i] !== y_dut[i]) begin
        differ  = 1'b1;
        low_bit = 9'(i);
      end
    pad  = PW'(y_dut);
    fold = '0;
    for (int i = 0; i < NCH; i++) fold ^= pad[i*32 +: 32];
  end
  // Run FSM with registered verdict, counters and signature
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mismatch         <= 1'b0;
      fail_count       <= '0;
      first_fail_cycle <= '0;
      first_diff_bit   <= '0;
      signature        <= 32'hFFFFFFFF;
    end else if (start && (state == IDLE || state == DONE)) begin
      state            <= (WARMUP == 0) ? CMP : WARM;
      cnt              <= '0;
      busy             <= 1'b1;
      done             <= 1'b0;
      mismatch         <= 1'b0;
      fail_count       <= '0;
      first_fail_cycle <= '0;
      first_diff_bit   <= '0;
      signature        <= 32'hFFFFFFFF;
    end else if (valid && state == WARM) begin
      if (cnt == 16'(WARMUP - 1)) begin
        state <= CMP;
        cnt   <= '0;
      end else cnt <= cnt + 16'd1;
    end else if (valid && state == CMP) begin
      signature <= {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
      if (differ) begin
        mismatch <= 1'b1;
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        if (!mismatch) begin
          first_fail_cycle <= cnt;
          first_diff_bit   <= low_bit;
        end
      end
      if (cnt == 16'(NCYCLES - 1)) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_y_output_checker.sv
// tb_y_output_checker: randomized scenarios against a bit-level reference model of the checker
module tb_y_output_checker;
  localparam int W = 360;
  localparam int N = 22;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
  logic [W-1:0] y_ref = '0, y_dut = '0;
  logic busy, done, mismatch;
  logic [15:0] fail_count, first_fail_cycle;
  logic [8:0] first_diff_bit;
  logic [31:0] signature;
  int compared = 0, mismatched = 0;
  logic [W-1:0] sref[N], sdut[N];
  logic e_mis;
  logic [15:0] e_cnt, e_ffc;
  logic [8:0] e_fdb;
  logic [31:0] e_sig, zero_sig;
  logic early_done, busy_after, clear_after;

  y_output_checker dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .y_ref(y_ref), .y_dut(y_dut),
    .busy(busy), .done(done), .mismatch(mismatch), .fail_count(fail_count),
    .first_fail_cycle(first_fail_cycle), .first_diff_bit(first_diff_bit), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    logic [383:0] t;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [73:0] got();
    return {mismatch, fail_count, first_fail_cycle, first_diff_bit, signature};
  endfunction

  function automatic logic [73:0] expd();
    return {e_mis, e_cnt, e_ffc, e_fdb, e_sig};
  endfunction

  // Expected verdict: skip the first two samples, then judge the next twenty
  task automatic model();
    e_mis = 0; e_cnt = 0; e_ffc = 0; e_fdb = 0; e_sig = 32'hFFFFFFFF;
    for (int k = 2; k < N; k++) begin
      logic [31:0] f;
      bit found;
      int lo;
      f = '0; found = 0; lo = 0;
      for (int b = 0; b < W; b++) begin
        f[b % 32] ^= sdut[k][b];
        if (!found && sref[k][b] !== sdut[k][b]) begin found = 1; lo = b; end
      end
      if (found) begin
        if (!e_mis) begin e_ffc = 16'(k - 2); e_fdb = 9'(lo); end
        e_mis = 1;
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 1;
      end
      e_sig = (e_sig << 1) ^ (e_sig[31] ? POLY : 32'h0) ^ f;
    end
  endtask

  task automatic drive_run(input int gap_at, input int gap_len, input int n);
    @(negedge clk); start = 1; valid = 0;
    @(negedge clk); start = 0;
    busy_after = busy; clear_after = !done && !mismatch && fail_count == 0;
    early_done = 0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at)
        repeat (gap_len) begin
          valid = 0; start = 1; y_ref = rnd(); y_dut = rnd();
          @(negedge clk); start = 0;
          if (done) early_done = 1;
        end
      if (done) early_done = 1;
      valid = 1; y_ref = sref[k]; y_dut = sdut[k];
      @(negedge clk);
    end
    valid = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, done, got()} !== {2'b0, 42'b0, 32'hFFFFFFFF}) begin
      mismatched++;
      $display("FAIL reset: got %h exp %h", {busy, done, got()}, {2'b0, 42'b0, 32'hFFFFFFFF});
    end
    rst = 0;
  endtask

  task automatic test_zero();
    for (int k = 0; k < N; k++) begin sref[k] = '0; sdut[k] = '0; end
    model(); zero_sig = e_sig;
    drive_run(-1, 0, N);
    compared++;
    if ({busy_after, clear_after, early_done, busy, done} !== 5'b11001) begin
      mismatched++;
      $display("FAIL zero_flow: got %b exp 11001", {busy_after, clear_after, early_done, busy, done});
    end
    compared++;
    if (got() !== expd()) begin mismatched++; $display("FAIL zero_result: got %h exp %h", got(), expd()); end
  endtask

  task automatic test_flip();
    for (int k = 0; k < N; k++) begin sref[k] = rnd(); sdut[k] = sref[k]; end
    sdut[7][37] = ~sdut[7][37];
    model();
    drive_run(-1, 0, N);
    compared++;
    if ({done, got()} !== {1'b1, 1'b1, 16'd1, 16'd5, 9'd37, e_sig}) begin
      mismatched++;
      $display("FAIL flip37: got %h exp %h", {done, got()}, {1'b1, 1'b1, 16'd1, 16'd5, 9'd37, e_sig});
    end
  endtask

  task automatic test_warmup();
    for (int k = 0; k < N; k++) begin sref[k] = rnd(); sdut[k] = sref[k]; end
    sdut[0] = rnd(); sdut[1] = ~sref[1];
    model();
    drive_run(-1, 0, N);
    compared++;
    if (mismatch !== 1'b0 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL warmup_ignored: got mis=%b done=%b exp mis=0 done=1", mismatch, done);
    end
    compared++;
    if (got() !== expd()) begin mismatched++; $display("FAIL warmup_result: got %h exp %h", got(), expd()); end
  endtask

  task automatic test_gap();
    for (int k = 0; k < N; k++) begin
      sref[k] = rnd(); sdut[k] = sref[k];
      if ($urandom_range(3) == 0) sdut[k][$urandom_range(W - 1)] ^= 1'b1;
    end
    model();
    drive_run(12, 3, N);
    compared++;
    if ({early_done, done} !== 2'b01) begin
      mismatched++;
      $display("FAIL gap_done: got early=%b done=%b exp early=0 done=1", early_done, done);
    end
    compared++;
    if (got() !== expd()) begin mismatched++; $display("FAIL gap_result: got %h exp %h", got(), expd()); end
  endtask

  task automatic test_xbit();
    for (int k = 0; k < N; k++) begin sref[k] = rnd(); sdut[k] = sref[k]; end
    sref[2][W-1] = 1'b0;
    sdut[2][W-1] = 1'bx;
    model();
    drive_run(-1, 0, N);
    compared++;
    if (got() !== expd()) begin mismatched++; $display("FAIL xbit: got %h exp %h", got(), expd()); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < N; k++) begin sref[k] = rnd(); sdut[k] = ~sref[k]; end
    drive_run(-1, 0, 12);
    compared++;
    if ({busy, mismatch, fail_count} !== {2'b11, 16'd10}) begin
      mismatched++;
      $display("FAIL pre_reset: got %h exp %h", {busy, mismatch, fail_count}, {2'b11, 16'd10});
    end
    rst = 1; valid = 1; y_ref = sref[12]; y_dut = sdut[12];
    @(negedge clk); rst = 0; valid = 0;
    compared++;
    if ({busy, done, got()} !== {2'b0, 42'b0, 32'hFFFFFFFF}) begin
      mismatched++;
      $display("FAIL mid_reset: got %h exp %h", {busy, done, got()}, {2'b0, 42'b0, 32'hFFFFFFFF});
    end
    for (int k = 0; k < N; k++) begin sref[k] = '0; sdut[k] = '0; end
    drive_run(-1, 0, N);
    compared++;
    if ({done, got()} !== {1'b1, 42'b0, zero_sig}) begin
      mismatched++;
      $display("FAIL rerun: got %h exp %h", {done, got()}, {1'b1, 42'b0, zero_sig});
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int dens;
      dens = $urandom_range(4);
      for (int k = 0; k < N; k++) begin
        sref[k] = rnd(); sdut[k] = sref[k];
        if ($urandom_range(4) < dens) sdut[k][$urandom_range(W - 1)] ^= 1'b1;
        if (dens == 4 && k[0]) sdut[k] = rnd();
      end
      model();
      drive_run($urandom_range(N - 1), $urandom_range(3), N);
      compared++;
      if ({early_done, done, got()} !== {2'b01, expd()}) begin
        mismatched++;
        $display("FAIL random%0d: got %h exp %h", r, {early_done, done, got()}, {2'b01, expd()});
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_flip();
    test_warmup();
    test_gap();
    test_xbit();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
